// File: rtl/vga_pkg.sv
// Shared VGA definitions: receiver FSM state, default active geometry and
// standard 640x480@60 timing totals for sources and benches.
package vga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VSYNC = 2'd1,
        ST_FRAME = 2'd2
    } state_t;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = 800;

    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = 525;

    // Internal counters are wider than the pixel coordinates and saturate,
    // so an endless blank_n-high run can never wrap back into range.
    localparam int CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/edge_det.sv
// Registers a 1-bit input and derives rise/fall strobes from the registered
// sample and its predecessor.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_d;
    logic r_d_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d      <= 1'b0;
            r_d_prev <= 1'b0;
        end else begin
            r_d      <= i_d;
            r_d_prev <= r_d;
        end
    end

    assign o_level = r_d;
    assign o_rise  = r_d & ~r_d_prev;
    assign o_fall  = ~r_d & r_d_prev;

endmodule

// File: rtl/vga_rx.sv
// VGA capture: pixels framed by blank_n, frames by vsync; checks geometry
// against H_SIZE x V_SIZE and reports lock/err. hsync is ignored.
module vga_rx
    import vga_pkg::*;
#(
    parameter int H_SIZE = H_ACTIVE,
    parameter int V_SIZE = V_ACTIVE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vga_hsync,
    input  logic        vga_vsync,
    input  logic        vga_blank_n,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [23:0] pix_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic        locked,
    output logic        err,
    output state_t      dbg_state
);

    localparam logic [CNT_W-1:0] H_LIM = CNT_W'(H_SIZE);
    localparam logic [CNT_W-1:0] V_LIM = CNT_W'(V_SIZE);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [23:0]      r_rgb;
    logic [CNT_W-1:0] r_pix_cnt;
    logic [CNT_W-1:0] r_line_cnt;
    logic [CNT_W-1:0] w_lines_seen;
    logic             r_bad;

    logic w_vs_rise, w_vs_fall, w_unused_vs_level;
    logic w_bn_level, w_bn_fall, w_unused_bn_rise;
    logic w_unused_hsync;

    logic w_frame_begin, w_frame_end, w_pix_act, w_pix_ok;
    logic w_line_end, w_line_err, w_frame_err, w_bad_now;

    assign w_unused_hsync = vga_hsync;

    edge_det u_vs_edge (
        .clk     (clk),
        .rst     (rst),
        .i_d     (vga_vsync),
        .o_level (w_unused_vs_level),
        .o_rise  (w_vs_rise),
        .o_fall  (w_vs_fall)
    );

    edge_det u_bn_edge (
        .clk     (clk),
        .rst     (rst),
        .i_d     (vga_blank_n),
        .o_level (w_bn_level),
        .o_rise  (w_unused_bn_rise),
        .o_fall  (w_bn_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rgb <= '0;
        else     r_rgb <= {vga_r, vga_g, vga_b};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_vs_fall) w_state_nxt = ST_VSYNC;
            ST_VSYNC: if (w_vs_rise) w_state_nxt = ST_FRAME;
            ST_FRAME: if (w_vs_fall) w_state_nxt = ST_VSYNC;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // A line ending in the same cycle as vsync falls is counted before the
    // frame-length check, hence w_lines_seen rather than r_line_cnt.
    always_comb begin
        w_frame_begin = (r_state == ST_VSYNC) && w_vs_rise;
        w_frame_end   = (r_state == ST_FRAME) && w_vs_fall;
        w_pix_act     = (r_state == ST_FRAME) && w_bn_level;
        w_line_end    = (r_state == ST_FRAME) && w_bn_fall;
        w_pix_ok      = w_pix_act && (r_pix_cnt < H_LIM) && (r_line_cnt < V_LIM);
        w_line_err    = w_line_end && (r_pix_cnt != H_LIM);
        w_lines_seen  = w_line_end ? sat_inc(r_line_cnt) : r_line_cnt;
        w_frame_err   = w_frame_end && (w_lines_seen != V_LIM);
        w_bad_now     = (w_pix_act && !w_pix_ok) || w_line_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
            r_bad      <= 1'b0;
        end else if (w_frame_begin) begin
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
            r_bad      <= 1'b0;
        end else begin
            if (w_pix_act) r_pix_cnt <= sat_inc(r_pix_cnt);
            if (w_line_end) begin
                r_pix_cnt  <= '0;
                r_line_cnt <= w_lines_seen;
            end
            if (w_bad_now) r_bad <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_data    <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            locked      <= 1'b0;
            err         <= 1'b0;
        end else begin
            pix_valid   <= w_pix_ok;
            frame_start <= w_frame_begin;
            frame_done  <= w_frame_end;
            err         <= w_line_err || w_frame_err;
            if (w_pix_ok) begin
                pix_x    <= r_pix_cnt[9:0];
                pix_y    <= r_line_cnt[8:0];
                pix_data <= r_rgb;
            end
            if (w_frame_end) locked <= !(r_bad || w_bad_now || w_frame_err);
        end
    end

    assign dbg_state = r_state;

endmodule

// File: tb/tb_vga_rx.sv
// Randomised frame-level stimulus for vga_rx at 8x4 geometry, checked
// cycle-exactly against expected pixel/frame/err event queues.
module tb_vga_rx;
    import vga_pkg::*;

    localparam int TB_H = 8;
    localparam int TB_V = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vga_hsync = 1'b1;
    logic        vga_vsync = 1'b1;
    logic        vga_blank_n = 1'b0;
    logic [7:0]  vga_r = '0, vga_g = '0, vga_b = '0;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [23:0] pix_data;
    logic        frame_start, frame_done, locked, err;
    state_t      dbg_state;

    vga_rx #(.H_SIZE(TB_H), .V_SIZE(TB_V)) dut (
        .clk         (clk),
        .rst         (rst),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .vga_blank_n (vga_blank_n),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_data    (pix_data),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .locked      (locked),
        .err         (err),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;

    int          exp_pix_cyc_q[$];
    logic [42:0] exp_pix_q[$];
    int          exp_fs_q[$];
    int          exp_fd_q[$];
    logic        exp_lock_q[$];
    int          exp_err_q[$];
    logic        exp_lock_lvl = 1'b0;
    logic [42:0] last_pix = '0;

    // reference model of the receiver, at frame/line level
    bit m_armed = 0, m_in_frame = 0, m_bad = 0;
    bit m_prev_vs = 0, m_prev_bn = 0;
    int m_x = 0, m_y = 0;
    int line_len[8];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic vs, input logic bn, input logic [23:0] d);
        int t;
        bit line_err, frame_err;
        @(negedge clk);
        vga_vsync   = vs;
        vga_blank_n = bn;
        vga_hsync   = 1'($urandom_range(0, 1));
        {vga_r, vga_g, vga_b} = d;
        t = cyc + 2;
        line_err  = 0;
        frame_err = 0;
        if (m_in_frame) begin
            if (bn) begin
                if (m_x < TB_H && m_y < TB_V) begin
                    exp_pix_cyc_q.push_back(t);
                    exp_pix_q.push_back({10'(m_x), 9'(m_y), d});
                end else begin
                    m_bad = 1;
                end
                m_x++;
            end else if (m_prev_bn) begin
                line_err = (m_x != TB_H);
                m_y++;
                m_x = 0;
            end
            if (line_err) m_bad = 1;
            if (!vs && m_prev_vs) begin
                frame_err = (m_y != TB_V);
                exp_fd_q.push_back(t);
                exp_lock_q.push_back(!(m_bad || frame_err));
                m_in_frame = 0;
                m_armed    = 1;
            end
            if (line_err || frame_err) exp_err_q.push_back(t);
        end else if (m_armed) begin
            if (vs && !m_prev_vs) begin
                exp_fs_q.push_back(t);
                m_in_frame = 1;
                m_armed    = 0;
                m_x = 0;
                m_y = 0;
                m_bad = 0;
            end
        end else if (!vs && m_prev_vs) begin
            m_armed = 1;
        end
        m_prev_vs = vs;
        m_prev_bn = bn;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_valid"}, pix_valid, 0);
        check_eq({tag, "_xyd"}, {pix_x, pix_y, pix_data}, 0);
        check_eq({tag, "_pulses"}, {frame_start, frame_done, err}, 0);
        check_eq({tag, "_locked"}, locked, 0);
        check_eq({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    task automatic do_reset();
        int c;
        @(negedge clk);
        #2;
        rst = 1'b1;
        c = cyc;
        while (exp_pix_cyc_q.size() > 0 && exp_pix_cyc_q[$] > c) begin
            void'(exp_pix_cyc_q.pop_back());
            void'(exp_pix_q.pop_back());
        end
        while (exp_fs_q.size() > 0 && exp_fs_q[$] > c) void'(exp_fs_q.pop_back());
        while (exp_fd_q.size() > 0 && exp_fd_q[$] > c) begin
            void'(exp_fd_q.pop_back());
            void'(exp_lock_q.pop_back());
        end
        while (exp_err_q.size() > 0 && exp_err_q[$] > c) void'(exp_err_q.pop_back());
        m_armed = 0; m_in_frame = 0; m_bad = 0;
        m_prev_vs = 0; m_prev_bn = 0;
        exp_lock_lvl = 1'b0;
        last_pix = '0;
        #1;
        check_outputs_zero("rst_mid");
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic set_lines(input int len);
        for (int i = 0; i < 8; i++) line_len[i] = len;
    endtask

    // One frame: vsync low, back porch, n_lines lines, then (unless tight)
    // blanking. The next frame's vsync fall closes it.
    task automatic do_frame(input int n_lines, input bit tight, input bit bn_in_vs,
                            input bit pat, input int rst_line, input int rst_pix);
        int vs_len, hp;
        logic [23:0] d;
        vs_len = bn_in_vs ? 7 : V_SYNC + int'($urandom_range(0, 2));
        for (int i = 0; i < vs_len; i++)
            drive(1'b0, (bn_in_vs && i >= 1 && i < 5), 24'($urandom));
        hp = int'($urandom_range(1, 3));
        for (int i = 0; i < hp; i++) drive(1'b1, 1'b0, 24'($urandom));
        for (int y = 0; y < n_lines; y++) begin
            for (int x = 0; x < line_len[y]; x++) begin
                if (y == rst_line && x == rst_pix) begin
                    do_reset();
                    return;
                end
                d = pat ? 24'(x + 16 * y) : 24'($urandom);
                drive(1'b1, 1'b1, d);
            end
            hp = (tight && y == n_lines - 1) ? 0 : int'($urandom_range(1, 3));
            for (int i = 0; i < hp; i++) drive(1'b1, 1'b0, 24'($urandom));
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int   mon_c;
    logic mon_l;

    always @(negedge clk) begin
        if (pix_valid || (exp_pix_cyc_q.size() > 0 && exp_pix_cyc_q[0] == cyc)) begin
            if (exp_pix_cyc_q.size() == 0) begin
                check_eq("pix_extra", {pix_x, pix_y, pix_data}, 0);
            end else begin
                mon_c = exp_pix_cyc_q.pop_front();
                last_pix = exp_pix_q.pop_front();
                check_eq("pix_cycle", cyc, mon_c);
                check_eq("pix_valid", pix_valid, 1);
                check_eq("pix_xyd", {pix_x, pix_y, pix_data}, last_pix);
            end
        end else begin
            check_eq("pix_hold", {pix_x, pix_y, pix_data}, last_pix);
        end

        if (frame_start || (exp_fs_q.size() > 0 && exp_fs_q[0] == cyc)) begin
            if (exp_fs_q.size() == 0) check_eq("fs_extra", frame_start, 0);
            else begin
                mon_c = exp_fs_q.pop_front();
                check_eq("fs_cycle", cyc, mon_c);
                check_eq("fs_pulse", frame_start, 1);
            end
        end

        if (frame_done || (exp_fd_q.size() > 0 && exp_fd_q[0] == cyc)) begin
            if (exp_fd_q.size() == 0) check_eq("fd_extra", frame_done, 0);
            else begin
                mon_c = exp_fd_q.pop_front();
                mon_l = exp_lock_q.pop_front();
                check_eq("fd_cycle", cyc, mon_c);
                check_eq("fd_pulse", frame_done, 1);
                exp_lock_lvl = mon_l;
            end
        end
        check_eq("locked", locked, exp_lock_lvl);

        if (err || (exp_err_q.size() > 0 && exp_err_q[0] == cyc)) begin
            if (exp_err_q.size() == 0) check_eq("err_extra", err, 0);
            else begin
                mon_c = exp_err_q.pop_front();
                check_eq("err_cycle", cyc, mon_c);
                check_eq("err_pulse", err, 1);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        check_outputs_zero("rst_init");
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 24'($urandom));

        // clean frame with x+16*y data
        set_lines(TB_H);
        do_frame(TB_V, 0, 0, 1, -1, -1);
        // short line 2
        line_len[2] = TB_H - 1;
        do_frame(TB_V, 0, 0, 1, -1, -1);
        // one line too many
        set_lines(TB_H);
        do_frame(TB_V + 1, 0, 0, 1, -1, -1);
        // blank_n pulse during vsync, clean frame
        do_frame(TB_V, 0, 1, 1, -1, -1);
        // last line ends in the same cycle as the next vsync fall
        do_frame(TB_V, 1, 0, 0, -1, -1);
        line_len[TB_V - 1] = TB_H + 1;
        do_frame(TB_V, 1, 0, 0, -1, -1);
        set_lines(TB_H);
        do_frame(TB_V - 1, 1, 0, 0, -1, -1);
        // reset mid-frame, then two clean frames
        do_frame(TB_V, 0, 0, 1, 1, 3);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 24'($urandom));
        do_frame(TB_V, 0, 0, 1, -1, -1);
        do_frame(TB_V, 0, 0, 1, -1, -1);

        // randomised frames
        for (int f = 0; f < 200; f++) begin
            int nl;
            nl = ($urandom_range(0, 3) == 0) ? TB_V - 1 + int'($urandom_range(0, 2)) : TB_V;
            for (int y = 0; y < 8; y++)
                line_len[y] = ($urandom_range(0, 5) == 0) ? TB_H - 2 + int'($urandom_range(0, 4)) : TB_H;
            do_frame(nl, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), 0, -1, -1);
        end

        // closing vsync fall, then let the pipeline drain
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 24'($urandom));

        check_eq("left_pix", exp_pix_cyc_q.size(), 0);
        check_eq("left_fs", exp_fs_q.size(), 0);
        check_eq("left_fd", exp_fd_q.size(), 0);
        check_eq("left_err", exp_err_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
